// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RISC-V core control blocks: boot sequencer state
// encodings and default datapath widths.
package riscv_ctrl_pkg;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_RES_W  = 64;
   localparam int unsigned DEF_CYC_W  = 16;

   // Encodings are visible on the state output port, so they are fixed.
   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_LOAD = 2'd1,
      SEQ_RUN  = 2'd2,
      SEQ_HALT = 2'd3
   } seq_state_e;

endpackage

// File: rtl/seq_cycle_budget.sv
// Run-cycle counter for the boot sequencer. start_i clears the count and
// latches the budget; the count then advances on every enabled cycle.
// expire_o flags the last cycle of a non-zero budget. A zero budget never
// expires. The count saturates instead of wrapping.
module seq_cycle_budget #(
   parameter int unsigned CYC_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [CYC_W-1:0] budget_i,
   input  logic             en_i,
   output logic             expire_o
);

   logic [CYC_W-1:0] count_q, count_d;
   logic [CYC_W-1:0] budget_q, budget_d;

   // Counter and latched budget; synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q  <= '0;
         budget_q <= '0;
      end else begin
         count_q  <= count_d;
         budget_q <= budget_d;
      end
   end

   // Next count: restart on start_i, otherwise advance while enabled.
   always_comb begin
      count_d  = count_q;
      budget_d = budget_q;
      if (start_i) begin
         count_d  = '0;
         budget_d = budget_i;
      end else if (en_i && (count_q != {CYC_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   // The count equals budget-1 on the last enabled cycle.
   always_comb begin
      expire_o = en_i && (budget_q != '0) && (count_q == budget_q - 1'b1);
   end

endmodule

// File: rtl/imem_boot_sequencer.sv
// Boot sequencer for the single-cycle RISC-V core. It streams a program from
// the host into instruction memory while the core is held in reset. It then
// releases the core for a bounded number of cycles, halts it, and captures
// the core result.
module imem_boot_sequencer
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned RES_W  = DEF_RES_W,
   parameter int unsigned CYC_W  = DEF_CYC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   input  logic [CYC_W-1:0]  run_cycles,
   input  logic              stop,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_rst_n,
   input  logic [RES_W-1:0]  cpu_res,
   output logic [RES_W-1:0]  res_out,
   output logic              res_valid,
   output logic [1:0]        state,
   output logic [ADDR_W:0]   load_count,
   output logic              overflow
);

   seq_state_e state_q, state_d;

   logic [ADDR_W:0]   load_count_q, load_count_d;
   logic              overflow_q, overflow_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
   logic [RES_W-1:0]  res_out_q, res_out_d;
   logic              res_valid_q, res_valid_d;

   logic accept;         // beat handshake completes this cycle
   logic last_slot;      // next write targets the final imem word
   logic mem_full;       // load_count has reached the imem depth
   logic load_req;       // load_start honoured in the current state
   logic run_start;      // LOAD -> RUN transition this cycle
   logic run_end;        // RUN -> HALT transition this cycle
   logic budget_expire;

   // The count saturates exactly at the depth, so the top bit alone marks "full".
   assign mem_full  = load_count_q[ADDR_W];
   assign last_slot = (load_count_q[ADDR_W-1:0] == {ADDR_W{1'b1}});

   seq_cycle_budget #(
      .CYC_W (CYC_W)
   ) u_budget (
      .clk_i    (clk),
      .rst_ni   (rst),
      .start_i  (run_start),
      .budget_i (run_cycles),
      .en_i     (state_q == SEQ_RUN),
      .expire_o (budget_expire)
   );

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= SEQ_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. stop takes priority over any beat in LOAD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SEQ_IDLE: begin
            if (load_start) state_d = SEQ_LOAD;
         end
         SEQ_LOAD: begin
            if (stop) begin
               state_d = SEQ_IDLE;
            end else if (accept && (s_last || last_slot)) begin
               state_d = SEQ_RUN;
            end
         end
         SEQ_RUN: begin
            if (stop || budget_expire) state_d = SEQ_HALT;
         end
         SEQ_HALT: begin
            if (load_start) state_d = SEQ_LOAD;
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   // FSM-decoded outputs and handshake.
   always_comb begin
      s_ready   = (state_q == SEQ_LOAD) && !mem_full && !stop;
      accept    = s_ready && s_valid;
      cpu_rst_n = (state_q == SEQ_RUN);
      load_req  = load_start && ((state_q == SEQ_IDLE) || (state_q == SEQ_HALT));
      run_start = (state_q == SEQ_LOAD) && (state_d == SEQ_RUN);
      run_end   = (state_q == SEQ_RUN) && (state_d == SEQ_HALT);
   end

   // ---------------------------------------------------------------------------
   // Load address counter, imem write port and result capture
   // ---------------------------------------------------------------------------

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         load_count_q <= '0;
         overflow_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         res_out_q    <= '0;
         res_valid_q  <= 1'b0;
      end else begin
         load_count_q <= load_count_d;
         overflow_q   <= overflow_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         res_out_q    <= res_out_d;
         res_valid_q  <= res_valid_d;
      end
   end

   // Next-state datapath. Each accepted beat produces exactly one write strobe
   // on the following cycle. The result is sampled on the final released cycle.
   always_comb begin
      load_count_d = load_count_q;
      overflow_d   = overflow_q;
      imem_we_d    = accept;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      res_out_d    = res_out_q;
      res_valid_d  = res_valid_q;

      if (load_req) begin
         load_count_d = '0;
         overflow_d   = 1'b0;
         res_valid_d  = 1'b0;
      end

      if (accept) begin
         imem_addr_d  = load_count_q[ADDR_W-1:0];
         imem_wdata_d = s_data;
         load_count_d = load_count_q + 1'b1;
         // Memory filled without an end-of-program marker.
         if (last_slot && !s_last) overflow_d = 1'b1;
      end

      if (run_end) begin
         res_out_d   = cpu_res;
         res_valid_d = 1'b1;
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign res_out    = res_out_q;
   assign res_valid  = res_valid_q;
   assign state      = state_q;
   assign load_count = load_count_q;
   assign overflow   = overflow_q;

endmodule
